enemy_bullet: RTL and testbench

Per-enemy projectile generator, downstream of each enemy ship instance. Consumes the ship's position and dead flag, fires a bullet straight down from the ship's centre every fire_delay_p frames and advances it once per frame. Reports a one-cycle player_hit_o pulse on collision with the player band. Drives the bullet box and colour into the VGA compositor.

---
 rtl/enemy_pkg.sv | 30 +++
 rtl/enemy_bullet_if.sv | 37 +++
 rtl/box_overlap.sv | 17 +
 rtl/enemy_bullet.sv | 140 ++++++++++++++
 tb/tb_enemy_bullet.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy projectile logic.
package enemy_pkg;

  // One-hot bullet controller states.
  typedef enum logic [3:0] {
    StIdle     = 4'b0001,
    StCooldown = 4'b0010,
    StFlying   = 4'b0100,
    StHalt     = 4'b1000
  } bullet_state_e;

  localparam int unsigned ScreenW    = 640;
  localparam int unsigned ScreenH    = 480;
  localparam logic [9:0]  ScreenBot  = 10'(ScreenH - 1);
  localparam logic [9:0]  RightLimit = 10'(ScreenW - 11);

  // 12-bit RGB is packed as {R, G, B}, 4 bits each.
  function automatic logic [3:0] rgb_red(input logic [11:0] c);
    return c[11:8];
  endfunction

  function automatic logic [3:0] rgb_green(input logic [11:0] c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] rgb_blue(input logic [11:0] c);
    return c[3:0];
  endfunction

endpackage

// File: rtl/enemy_bullet_if.sv
// Signal bundle between an enemy ship / VGA front end and its bullet generator.
interface enemy_bullet_if;
  logic       frame_i;
  logic       start_i;
  logic       enemy_dead_i;
  logic [9:0] enemy_left_i;
  logic [9:0] enemy_right_i;
  logic [9:0] enemy_bot_i;
  logic [9:0] player_left_i;
  logic [9:0] player_right_i;
  logic [9:0] pixel_x_i;
  logic [9:0] pixel_y_i;
  logic [9:0] bullet_left_o;
  logic [9:0] bullet_right_o;
  logic [9:0] bullet_top_o;
  logic [9:0] bullet_bot_o;
  logic       active_o;
  logic       player_hit_o;
  logic       draw_o;
  logic [3:0] bullet_red_o;
  logic [3:0] bullet_green_o;
  logic [3:0] bullet_blue_o;

  modport slave (
    input  frame_i, start_i, enemy_dead_i, enemy_left_i, enemy_right_i, enemy_bot_i,
    input  player_left_i, player_right_i, pixel_x_i, pixel_y_i,
    output bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o,
    output active_o, player_hit_o, draw_o, bullet_red_o, bullet_green_o, bullet_blue_o
  );

  modport master (
    output frame_i, start_i, enemy_dead_i, enemy_left_i, enemy_right_i, enemy_bot_i,
    output player_left_i, player_right_i, pixel_x_i, pixel_y_i,
    input  bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o,
    input  active_o, player_hit_o, draw_o, bullet_red_o, bullet_green_o, bullet_blue_o
  );
endinterface

// File: rtl/box_overlap.sv
// Inclusive 1-D interval overlap test: [a_lo,a_hi] intersects [b_lo,b_hi].
module box_overlap #(
  parameter int unsigned Width = 10
) (
  input  logic [Width-1:0] a_lo,
  input  logic [Width-1:0] a_hi,
  input  logic [Width-1:0] b_lo,
  input  logic [Width-1:0] b_hi,
  output logic             overlap
);

  // Two closed intervals overlap unless one ends before the other starts.
  always_comb begin
    overlap = (a_lo <= b_hi) && (b_lo <= a_hi);
  end

endmodule

// File: rtl/enemy_bullet.sv
// Per-enemy bullet: waits a number of frames, fires straight down, reports player hits.
module enemy_bullet
  import enemy_pkg::*;
#(
  parameter logic [11:0] color_p      = 12'hF00,
  parameter logic [15:0] fire_delay_p = 16'd10,
  parameter logic [9:0]  speed_p      = 10'd4,
  parameter logic [9:0]  bullet_w_p   = 10'd2,
  parameter logic [9:0]  bullet_h_p   = 10'd8,
  parameter logic [9:0]  player_top_p = 10'd440,
  parameter logic [9:0]  screen_bot_p = ScreenBot
) (
  input logic           clk_i,
  input logic           reset_i,
  enemy_bullet_if.slave bus
);

  bullet_state_e state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [9:0]    left_q, left_d, right_q, right_d, top_q, top_d, bot_q, bot_d;
  logic          active_q, active_d, hit_q, hit_d;

  logic [9:0]  spawn_left;
  logic [10:0] next_top, next_bot;
  logic        overlap, hit_now, exit_now;

  box_overlap #(.Width(10)) u_overlap (
    .a_lo    (left_q),
    .a_hi    (right_q),
    .b_lo    (bus.player_left_i),
    .b_hi    (bus.player_right_i),
    .overlap (overlap)
  );

  // Spawn column and the 11-bit (non-wrapping) next position for hit/exit decisions.
  always_comb begin
    spawn_left = bus.enemy_left_i + ((bus.enemy_right_i - bus.enemy_left_i) >> 1)
                 - (bullet_w_p >> 1);
    next_top   = {1'b0, top_q} + {1'b0, speed_p};
    next_bot   = {1'b0, bot_q} + {1'b0, speed_p};
    hit_now    = (next_bot >= {1'b0, player_top_p}) && overlap;
    exit_now   = next_top > {1'b0, screen_bot_p};
  end

  // Next-state logic; hit outranks exit, and either ends the flight.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    right_d  = right_q;
    top_d    = top_q;
    bot_d    = bot_q;
    active_d = active_q;
    hit_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StCooldown;
          cnt_d   = fire_delay_p;
        end
      end
      StCooldown: begin
        if (bus.enemy_dead_i) begin
          state_d = StHalt;
        end else if (bus.frame_i) begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            left_d   = spawn_left;
            right_d  = spawn_left + bullet_w_p - 10'd1;
            top_d    = bus.enemy_bot_i + 10'd1;
            bot_d    = bus.enemy_bot_i + bullet_h_p;
            active_d = 1'b1;
            state_d  = StFlying;
          end
        end
      end
      StFlying: begin
        if (bus.frame_i) begin
          if (hit_now || exit_now) begin
            hit_d    = hit_now;
            active_d = 1'b0;
            cnt_d    = fire_delay_p;
            state_d  = bus.enemy_dead_i ? StHalt : StCooldown;
          end else begin
            top_d = next_top[9:0];
            bot_d = next_bot[9:0];
          end
        end
      end
      StHalt: begin
        if (bus.start_i && !bus.enemy_dead_i) begin
          state_d = StCooldown;
          cnt_d   = fire_delay_p;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and position registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= fire_delay_p;
      left_q   <= '0;
      right_q  <= '0;
      top_q    <= '0;
      bot_q    <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      active_q <= active_d;
      hit_q    <= hit_d;
    end
  end

  // Outputs, pixel hit test for the compositor and fixed colour.
  always_comb begin
    bus.bullet_left_o  = left_q;
    bus.bullet_right_o = right_q;
    bus.bullet_top_o   = top_q;
    bus.bullet_bot_o   = bot_q;
    bus.active_o       = active_q;
    bus.player_hit_o   = hit_q;
    bus.draw_o         = active_q
                         && (left_q <= bus.pixel_x_i) && (bus.pixel_x_i <= right_q)
                         && (top_q <= bus.pixel_y_i) && (bus.pixel_y_i <= bot_q);
    bus.bullet_red_o   = rgb_red(color_p);
    bus.bullet_green_o = rgb_green(color_p);
    bus.bullet_blue_o  = rgb_blue(color_p);
  end

endmodule

// File: tb/tb_enemy_bullet.sv
// Self-checking bench for enemy_bullet: directed scenarios plus random traffic vs a model.
module tb_enemy_bullet;

  localparam int Fd = 10, Spd = 4, Bw = 2, Bh = 8, PTop = 440, SBot = 479;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  enemy_bullet_if bus ();

  enemy_bullet dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase 0 idle, 1 waiting to fire, 2 bullet in the air, 3 ship gone quiet.
  int m_phase, m_wait, m_left, m_right, m_top, m_bot;
  bit m_active, m_hit;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_wait = Fd;
    m_left = 0; m_right = 0; m_top = 0; m_bot = 0;
    m_active = 0; m_hit = 0;
  endtask

  task automatic model_step();
    int el, er, nt, nb;
    bit struck;
    m_hit = 0;
    if (m_phase == 0) begin
      if (bus.start_i) begin m_phase = 1; m_wait = Fd; end
    end else if (m_phase == 1) begin
      if (bus.enemy_dead_i) m_phase = 3;
      else if (bus.frame_i) begin
        if (m_wait > 0) m_wait--;
        else begin
          el = int'(bus.enemy_left_i);
          er = int'(bus.enemy_right_i);
          m_left   = (el + (((er - el) & 1023) / 2) - Bw / 2) & 1023;
          m_right  = (m_left + Bw - 1) & 1023;
          m_top    = (int'(bus.enemy_bot_i) + 1) & 1023;
          m_bot    = (m_top + Bh - 1) & 1023;
          m_active = 1;
          m_phase  = 2;
        end
      end
    end else if (m_phase == 2) begin
      if (bus.frame_i) begin
        nt = m_top + Spd;
        nb = m_bot + Spd;
        struck = (nb >= PTop) && (m_left <= int'(bus.player_right_i))
                 && (int'(bus.player_left_i) <= m_right);
        if (struck) begin
          m_hit = 1; m_active = 0;
        end else if (nt > SBot) begin
          m_active = 0;
        end else begin
          m_top = nt; m_bot = nb;
        end
        if (!m_active) begin
          m_phase = bus.enemy_dead_i ? 3 : 1;
          m_wait  = Fd;
        end
      end
    end else begin
      if (bus.start_i && !bus.enemy_dead_i) begin m_phase = 1; m_wait = Fd; end
    end
  endtask

  task automatic compare_all();
    int px, py;
    bit d;
    px = int'(bus.pixel_x_i);
    py = int'(bus.pixel_y_i);
    d = m_active && (m_left <= px) && (px <= m_right) && (m_top <= py) && (py <= m_bot);
    check_eq("active", bus.active_o, m_active);
    check_eq("hit", bus.player_hit_o, m_hit);
    check_eq("left", bus.bullet_left_o, m_left);
    check_eq("right", bus.bullet_right_o, m_right);
    check_eq("top", bus.bullet_top_o, m_top);
    check_eq("bot", bus.bullet_bot_o, m_bot);
    check_eq("draw", bus.draw_o, d);
  endtask

  task automatic rand_pixel();
    if ($urandom_range(0, 1) == 1) begin
      bus.pixel_x_i = 10'((m_left + int'($urandom_range(0, 4)) - 2) & 1023);
      bus.pixel_y_i = 10'((m_top + int'($urandom_range(0, Bh + 3)) - 2) & 1023);
    end else begin
      bus.pixel_x_i = 10'($urandom_range(0, 639));
      bus.pixel_y_i = 10'($urandom_range(0, 479));
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic frame();
    bus.frame_i = 1'b1; rand_pixel(); tick();
    bus.frame_i = 1'b0; rand_pixel(); tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
  endtask

  initial begin
    bit saw_hit;
    int guard;
    rst_n = 1'b0;
    bus.frame_i = 0; bus.start_i = 0; bus.enemy_dead_i = 0;
    bus.enemy_left_i = 10'd100; bus.enemy_right_i = 10'd140; bus.enemy_bot_i = 10'd50;
    bus.player_left_i = 10'd300; bus.player_right_i = 10'd340;
    bus.pixel_x_i = 0; bus.pixel_y_i = 0;
    model_reset();
    tick(); tick();
    check_eq("rst_active", bus.active_o, 0);
    check_eq("rst_top", bus.bullet_top_o, 0);
    check_eq("red", bus.bullet_red_o, 15);
    check_eq("green", bus.bullet_green_o, 0);
    check_eq("blue", bus.bullet_blue_o, 0);
    rst_n = 1'b1;
    tick();

    // First shot only on the 11th frame after start.
    pulse_start();
    frames(10);
    check_eq("no_fire_10", bus.active_o, 0);
    bus.frame_i = 1'b1; tick(); bus.frame_i = 1'b0;
    check_eq("spawn_active", bus.active_o, 1);
    check_eq("spawn_left", bus.bullet_left_o, 119);
    check_eq("spawn_right", bus.bullet_right_o, 120);
    check_eq("spawn_top", bus.bullet_top_o, 51);
    check_eq("spawn_bot", bus.bullet_bot_o, 58);
    tick();

    // Miss: flies off the bottom on the 108th frame.
    saw_hit = 0;
    for (int i = 0; i < 107; i++) begin
      frame();
      if (bus.player_hit_o) saw_hit = 1;
    end
    check_eq("miss_top_479", bus.bullet_top_o, 479);
    check_eq("miss_still_active", bus.active_o, 1);
    frame();
    check_eq("miss_exit", bus.active_o, 0);
    check_eq("miss_top_hold", bus.bullet_top_o, 479);
    check_eq("miss_no_hit", saw_hit, 0);
    frames(10);
    check_eq("refire_not_yet", bus.active_o, 0);
    frame();
    check_eq("refire", bus.active_o, 1);
    check_eq("refire_top", bus.bullet_top_o, 51);

    // Hit: player under the ship.
    bus.player_left_i = 10'd100; bus.player_right_i = 10'd140;
    frames(95);
    check_eq("hit_pre_top", bus.bullet_top_o, 431);
    check_eq("hit_pre_bot", bus.bullet_bot_o, 438);
    bus.frame_i = 1'b1; tick(); bus.frame_i = 1'b0;
    check_eq("hit_pulse", bus.player_hit_o, 1);
    check_eq("hit_inactive", bus.active_o, 0);
    check_eq("hit_top_hold", bus.bullet_top_o, 431);
    tick();
    check_eq("hit_one_cycle", bus.player_hit_o, 0);

    // Dead during cooldown halts firing until restarted alive.
    bus.enemy_dead_i = 1'b1; tick();
    frames(50);
    check_eq("halt_no_fire", bus.active_o, 0);
    pulse_start();
    frames(20);
    check_eq("halt_dead_start", bus.active_o, 0);
    bus.enemy_dead_i = 1'b0;
    pulse_start();
    frames(10);
    check_eq("restart_not_yet", bus.active_o, 0);
    frame();
    check_eq("restart_fire", bus.active_o, 1);

    // Death mid-flight: bullet finishes its flight, then halts.
    bus.player_left_i = 10'd300; bus.player_right_i = 10'd340;
    frames(5);
    bus.enemy_dead_i = 1'b1;
    guard = 0;
    while (bus.active_o && guard < 200) begin frame(); guard++; end
    check_eq("dead_flight_ends", bus.active_o, 0);
    check_eq("dead_exit_top", bus.bullet_top_o, 479);
    bus.enemy_dead_i = 1'b0;
    frames(30);
    check_eq("dead_halt", bus.active_o, 0);

    // Random traffic against the model.
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      bus.frame_i = ($urandom_range(0, 2) == 0);
      bus.start_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) bus.enemy_dead_i = ~bus.enemy_dead_i;
      if ($urandom_range(0, 99) == 0) begin
        bus.enemy_left_i  = 10'($urandom_range(0, 600));
        bus.enemy_right_i = bus.enemy_left_i + 10'($urandom_range(0, 39));
        bus.enemy_bot_i   = 10'($urandom_range(0, 120));
      end
      if ($urandom_range(0, 99) == 0) begin
        bus.player_left_i  = 10'($urandom_range(0, 600));
        bus.player_right_i = bus.player_left_i + 10'($urandom_range(0, 60));
      end
      rand_pixel();
      tick();
    end

    // Asynchronous reset mid-flight.
    bus.frame_i = 0; bus.start_i = 0; bus.enemy_dead_i = 0;
    pulse_start();
    guard = 0;
    while (!bus.active_o && guard < 40) begin frame(); guard++; end
    check_eq("pre_rst_active", bus.active_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_active", bus.active_o, 0);
    check_eq("arst_hit", bus.player_hit_o, 0);
    check_eq("arst_left", bus.bullet_left_o, 0);
    check_eq("arst_right", bus.bullet_right_o, 0);
    check_eq("arst_top", bus.bullet_top_o, 0);
    check_eq("arst_bot", bus.bullet_bot_o, 0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
